// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults for the general-purpose register file. Issue
//               and writeback import these so that all stages agree on the
//               register width, the address width and the hard-zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_DATA_W    = 16;
  localparam int RF_ADDR_W    = 4;
  localparam int RF_ZERO_ADDR = 0;

  // True when the given index is the hard-wired zero register
  function automatic bit rf_is_zero_reg(input int addr, input bit zero_reg);
    return zero_reg && (addr == RF_ZERO_ADDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_cell.sv
`default_nettype none
// ============================================================================
// Module      : reg_cell
// Description : One architectural register plus its scoreboard busy bit.
//               A set and a clear on the same edge leave the bit set, because
//               the writeback release is ordered before the new reservation.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_cell
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              set_busy_i,
  input  logic              clr_busy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              busy_q;
  logic              busy_d;

  // Next state: write loads data; reservation outranks release on busy
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    if (we_i) begin
      data_d = d_i;
    end
    if (set_busy_i) begin
      busy_d = 1'b1;
    end else if (clr_busy_i) begin
      busy_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Register file with one write port, two registered read ports
//               with write-to-read bypass, and a per-register busy scoreboard
//               used by issue to stall on operands still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] w_data     [DEPTH];
  logic [DATA_W-1:0] w_data_nxt [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [DEPTH-1:0]  w_we;
  logic [DEPTH-1:0]  w_set;

  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_b_q;
  logic              busy_a_q;
  logic              busy_b_q;

  // A busy register can still be granted when writeback frees it this cycle.
  // The hard-zero register is never busy, so it is always granted.
  assign rsv_ok = rsv_en & (~w_busy[rsv_addr] | (w_en & (addr_c == rsv_addr)));

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      localparam logic [ADDR_W-1:0] c_ADDR      = ADDR_W'(i);
      localparam bit                c_HARD_ZERO = rf_is_zero_reg(i, ZERO_REG);

      assign w_we[i]  = !c_HARD_ZERO && w_en   && (addr_c   == c_ADDR);
      assign w_set[i] = !c_HARD_ZERO && rsv_ok && (rsv_addr == c_ADDR);

      reg_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_we[i]),
        .d_i        (data_c),
        .set_busy_i (w_set[i]),
        .clr_busy_i (w_we[i]),
        .data_o     (w_data[i]),
        .busy_o     (w_busy[i])
      );

      // Post-edge view of this register, used by the bypassing read ports
      assign w_data_nxt[i] = w_we[i] ? data_c : w_data[i];
      assign w_busy_nxt[i] = w_set[i] | (w_busy[i] & ~w_we[i]);
    end
  endgenerate

  // Read ports capture the register contents as updated by the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      data_a_q <= w_data_nxt[addr_a];
      data_b_q <= w_data_nxt[addr_b];
      busy_a_q <= w_busy_nxt[addr_a];
      busy_b_q <= w_busy_nxt[addr_b];
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;
  assign busy_a = busy_a_q;
  assign busy_b = busy_b_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Scoreboard bench for reg_file_sb. Two instances share one
//               stimulus stream: 16-bit/16-entry with hard-zero r0, and
//               32-bit/32-entry with an ordinary r0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [4:0]  addr_c;
  logic [31:0] data_c;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [15:0] d0_da, d0_db;
  logic        d0_ba, d0_bb, d0_ok;
  logic [31:0] d1_da, d1_db;
  logic        d1_ba, d1_bb, d1_ok;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .addr_c   (addr_c[3:0]),
    .data_c   (data_c[15:0]),
    .addr_a   (addr_a[3:0]),
    .addr_b   (addr_b[3:0]),
    .data_a   (d0_da),
    .data_b   (d0_db),
    .busy_a   (d0_ba),
    .busy_b   (d0_bb),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr[3:0]),
    .rsv_ok   (d0_ok)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .addr_c   (addr_c),
    .data_c   (data_c),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .data_a   (d1_da),
    .data_b   (d1_db),
    .busy_a   (d1_ba),
    .busy_b   (d1_bb),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (d1_ok)
  );

  typedef struct packed {
    logic [31:0] da;
    logic        ba;
    logic [31:0] db;
    logic        bb;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        m_reg[k][i]  = '0;
        m_busy[k][i] = 1'b0;
      end
  endfunction

  // Reference: release, then reservation, then read of the updated state
  function automatic void model_step(input int k, output bit ok, output exp_t e);
    int          nregs = (k == 0) ? 16 : 32;
    bit          zr    = (k == 0);
    logic [31:0] dm    = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    int          ac    = int'(addr_c)   % nregs;
    int          aa    = int'(addr_a)   % nregs;
    int          ab    = int'(addr_b)   % nregs;
    int          ra    = int'(rsv_addr) % nregs;
    bit          freed = w_en && (ac == ra) && !(zr && ac == 0);
    ok = rsv_en && (!m_busy[k][ra] || freed || (zr && ra == 0));
    if (w_en && !(zr && ac == 0)) begin
      m_reg[k][ac]  = data_c & dm;
      m_busy[k][ac] = 1'b0;
    end
    if (ok && !(zr && ra == 0)) m_busy[k][ra] = 1'b1;
    e.da = m_reg[k][aa];
    e.ba = m_busy[k][aa];
    e.db = m_reg[k][ab];
    e.bb = m_busy[k][ab];
  endfunction

  // One bus cycle: drive at negedge, check grant, queue expected reads
  task automatic cycle(input bit we, input logic [4:0] ac, input logic [31:0] dc,
                       input logic [4:0] aa, input logic [4:0] ab,
                       input bit re, input logic [4:0] ra);
    bit   ok;
    exp_t e;
    @(negedge clk);
    w_en = we; addr_c = ac; data_c = dc;
    addr_a = aa; addr_b = ab; rsv_en = re; rsv_addr = ra;
    #1;
    model_step(0, ok, e);
    check("rsv_ok dut0", 32'(d0_ok), 32'(ok));
    q0.push_back(e);
    model_step(1, ok, e);
    check("rsv_ok dut1", 32'(d1_ok), 32'(ok));
    q1.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    w_en = 1'b1; addr_c = 5'd9; data_c = 32'hDEAD_BEEF;
    rsv_en = 1'b1; rsv_addr = 5'd9; addr_a = 5'd9; addr_b = 5'd9;
    #1;
    model_reset();
    check("reset data_a dut0", 32'(d0_da), 32'h0);
    check("reset busy_b dut0", 32'(d0_bb), 32'h0);
    check("reset data_b dut1", d1_db, 32'h0);
    check("reset busy_a dut1", 32'(d1_ba), 32'h0);
    check("reset rsv_ok dut1", 32'(d1_ok), 32'h1);
    repeat (cycles) @(negedge clk);
    w_en = 1'b0; rsv_en = 1'b0;
    rst = 1'b1;
  endtask

  // Monitor: every edge presents a read result for each queued request
  initial begin
    exp_t me;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        me = q0.pop_front();
        check("data_a dut0", 32'(d0_da), me.da);
        check("busy_a dut0", 32'(d0_ba), 32'(me.ba));
        check("data_b dut0", 32'(d0_db), me.db);
        check("busy_b dut0", 32'(d0_bb), 32'(me.bb));
      end
      if (q1.size() > 0) begin
        me = q1.pop_front();
        check("data_a dut1", d1_da, me.da);
        check("busy_a dut1", 32'(d1_ba), 32'(me.ba));
        check("data_b dut1", d1_db, me.db);
        check("busy_b dut1", 32'(d1_bb), 32'(me.bb));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; w_en = 1'b0; addr_c = '0; data_c = '0;
    addr_a = '0; addr_b = '0; rsv_en = 1'b0; rsv_addr = '0;
    model_reset();
    do_reset(2);

    // Bypass on both ports; a read of another register sees its old value
    cycle(1'b1, 5'd4, 32'h0000_4444, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b1, 5'd3, 32'h0000_BEEF, 5'd3, 5'd3, 1'b0, 5'd0);
    cycle(1'b1, 5'd3, 32'h0000_CAFE, 5'd3, 5'd4, 1'b0, 5'd0);

    // Scoreboard reserve, refused re-reserve, release by write
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd1, 1'b1, 5'd7);
    cycle(1'b1, 5'd7, 32'h0000_00AA, 5'd7, 5'd7, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);

    // Release and re-reserve of the same register on one edge
    cycle(1'b0, 5'd0, 32'h0, 5'd2, 5'd2, 1'b1, 5'd2);
    cycle(1'b1, 5'd2, 32'h0000_5555, 5'd2, 5'd2, 1'b1, 5'd2);
    cycle(1'b0, 5'd0, 32'h0, 5'd2, 5'd2, 1'b0, 5'd0);

    // Register 0: hard zero on dut0, ordinary on dut1
    cycle(1'b1, 5'd0, 32'h0000_FFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);

    // Reset mid-stream discards written data
    cycle(1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd5, 1'b1, 5'd6);
    do_reset(1);
    cycle(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);

    // Unique pattern in every register, read back on both ports
    for (int i = 0; i < 32; i++)
      cycle(1'b1, 5'(i), (32'(i) * 32'h0101_0101) ^ 32'hF0F0_0000, 5'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);

    // Random traffic, addresses biased low to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ac, aa, ab, ra;
      ac = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      ab = ($urandom_range(0, 1) == 0) ? ac : 5'($urandom_range(0, 5));
      ra = ($urandom_range(0, 2) == 0) ? ac : 5'($urandom_range(0, 5));
      cycle(1'($urandom_range(0, 1)), ac, $urandom, aa, ab, 1'($urandom_range(0, 1)), ra);
    end

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(q0.size() + q1.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with one write port, two registered read ports, write-to-read bypass and a per-register busy scoreboard. It is the next-generation general-purpose register file of the 16-bit processor. It sits between the decode/issue stage, which reads operands and reserves destinations, and writeback, which writes results and releases reservations. The scoreboard lets issue stall on operands that are still pending from multi-cycle operations.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (derived, not overridable)
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- w_en  in  1  write strobe
- addr_c  in  ADDR_W  write address
- data_c  in  DATA_W  write data
- addr_a  in  ADDR_W  read address, port A
- addr_b  in  ADDR_W  read address, port B
- data_a  out  DATA_W  registered read data, port A
- data_b  out  DATA_W  registered read data, port B
- busy_a  out  1  registered busy bit of the register read on port A
- busy_b  out  1  registered busy bit of the register read on port B
- rsv_en  in  1  reservation request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  combinational grant for the current-cycle reservation

## Operation
- State: DEPTH x DATA_W data array, DEPTH-bit busy vector.
- Write: on an edge with w_en=1, reg[addr_c] <= data_c and busy[addr_c] <= 0. A write to a non-busy register is legal.
- Reservation: rsv_ok = rsv_en & (~busy[rsv_addr] | (w_en & addr_c==rsv_addr)). On an edge with rsv_ok=1, busy[rsv_addr] <= 1.
- Same address, same edge, write and grant: data is written and busy ends at 1. The release happens first, then the new reservation.
- rsv_en to a busy register with no same-cycle release: rsv_ok=0 and there is no state change. The requester retries.
- ZERO_REG=1 and address 0:
  - Writes are dropped.
  - Reservations return rsv_ok=1 but set nothing.
  - Reads return data 0, busy 0.
- Reads: on every edge, data_a/busy_a <= the contents and busy bit of addr_a as updated by that same edge. Port B behaves identically.
  - Bypass: w_en with addr_c==addr_a gives data_a <= data_c, busy_a <= 0, unless the same edge also grants a reservation on that address, in which case busy_a <= 1.
  - Both ports may read the same address, and either may equal addr_c.
- Widths: all addresses are full ADDR_W, so there is no out-of-range case. Data passes unmodified, with no arithmetic.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on data_*/busy_* after edge N.
- Write-to-read latency is 1 cycle via bypass: a write and a read of the same address at edge N return the new data after edge N.
- rsv_ok is combinational from rsv_en, rsv_addr, w_en, addr_c and the busy vector. There is no path from data inputs.
- Reset (rst=0, asynchronous):
  - All registers 0, all busy bits 0.
  - data_a=data_b=0, busy_a=busy_b=0.
  - rsv_ok evaluates with busy=0, so it equals rsv_en while in reset, but no reservation is recorded.
- Reset asserted mid-operation discards pending reservations and written data immediately. The first edge after deassertion behaves as normal operation.
- No handshake stalls inside the block. Every cycle accepts one write, one reservation and two reads.

## Structure
- Shared package rf_pkg holds the DATA_W/ADDR_W defaults and the zero-register address constant, so issue and writeback stages share them.
- One sub-module, reg_cell: a single DATA_W register plus its busy bit, with asynchronous active-low reset, write enable, set-busy and clear-busy inputs. Instantiate it DEPTH times via generate.
- Write-address decode, reservation grant logic and read muxes with bypass live in reg_file_sb.

## Test plan
- Reset: hold rst=0 mid-stream after writing 0x1234 to r5, release, read r5 on A -> data_a=0x0000, busy_a=0.
- Write/read with bypass: write r3=0xBEEF while addr_a=3, addr_b=3 same cycle -> next cycle data_a=data_b=0xBEEF. A read of r4 on the same edge returns its old value.
- Scoreboard:
  - Reserve r7 -> rsv_ok=1, then reading r7 gives busy_a=1.
  - A second reserve of r7 -> rsv_ok=0.
  - Write r7=0x00AA -> following read gives data=0x00AA, busy=0.
- Simultaneous release and reserve: r2 busy, same cycle w_en to r2 with 0x5555 and rsv r2 -> rsv_ok=1, next read data_a=0x5555, busy_a=1.
- Zero register (ZERO_REG=1): write r0=0xFFFF, reserve r0 -> rsv_ok=1, read r0 -> data 0, busy 0. With ZERO_REG=0, the same sequence gives 0xFFFF, busy 1.
- Parameter sweep: DATA_W=32, ADDR_W=5 -> write unique pattern to all 32 registers, read back via both ports, no aliasing.
